// File: rtl/phase_frame_sequencer_if.sv
// Byte-in / phase-write bundle between the SPI receiver, the sequencer
// and the phase register bank.
//   master : the sequencer (takes spi_cs/rx_*, drives wr_*/pulses/frame_cnt)
//   slave  : the surrounding environment (the mirror image)
interface phase_frame_sequencer_if #(
   parameter int PHASE_W = 6
);
   logic               spi_cs;
   logic               rx_valid;
   logic [7:0]         rx_byte;
   logic               wr_en;
   logic [5:0]         wr_addr;
   logic [PHASE_W-1:0] wr_data;
   logic               period_start;
   logic               apply_shift_all;
   logic               frame_err;
   logic               overrun;
   logic               range_err;
   logic [7:0]         frame_cnt;

   modport master (
      input  spi_cs, rx_valid, rx_byte,
      output wr_en, wr_addr, wr_data,
      output period_start, apply_shift_all,
      output frame_err, overrun, range_err, frame_cnt
   );

   modport slave (
      output spi_cs, rx_valid, rx_byte,
      input  wr_en, wr_addr, wr_data,
      input  period_start, apply_shift_all,
      input  frame_err, overrun, range_err, frame_cnt
   );
endinterface

// File: rtl/phase_frame_sequencer.sv
// Assigns SPI bytes to transducer channels and applies each full frame
// to the active phase bank only on a carrier-period boundary.
// Ports: master_clock, rst (async, active-low), bus (master modport:
//   spi_cs/rx_valid/rx_byte in; wr_*, period_start, apply_shift_all,
//   frame_err, overrun, range_err, frame_cnt out, all registered).
// Build option: PHASE_CLAMP_EN saturates out-of-range bytes and
//   reports them on range_err; otherwise bytes are taken modulo.
module phase_frame_sequencer #(
   parameter int NUM_CH  = 50,
   parameter int PHASE_W = 6,
   parameter int PERIOD  = 1250
) (
   input  logic                    master_clock,
   input  logic                    rst,
   phase_frame_sequencer_if.master bus
);
   localparam int ADDR_W = 6;
   localparam int CNT_W  = $clog2(PERIOD);

   typedef enum logic [1:0] {
      IDLE,
      RECV,
      PENDING
   } state_e;

   state_e             state_q, state_d;
   logic [ADDR_W-1:0]  idx_q, idx_d;
   logic               skid_full_q, skid_full_d;
   logic [7:0]         skid_q, skid_d;
   logic [CNT_W-1:0]   per_q, per_d;
   logic               wr_en_q, wr_en_d;
   logic [ADDR_W-1:0]  wr_addr_q, wr_addr_d;
   logic [PHASE_W-1:0] wr_data_q, wr_data_d;
   logic               ps_q, ps_d;
   logic               apply_q, apply_d;
   logic               ferr_q, ferr_d;
   logic               ovr_q, ovr_d;
   logic               rerr_q, rerr_d;
   logic [7:0]         fcnt_q, fcnt_d;

   logic               boundary;
   logic               src_vld;
   logic [7:0]         src;
   logic [PHASE_W-1:0] src_phase;
   logic               src_big;

   // Last count of the period: the registered outputs of this
   // cycle appear in the counter==0 cycle.
   assign boundary = (per_q == CNT_W'(PERIOD - 1));

   always_comb begin
      per_d = boundary ? '0 : per_q + 1'b1;
   end

`ifdef PHASE_CLAMP_EN
   localparam int STEPS = 1 << PHASE_W;

   assign src_big   = ({1'b0, src} >= 9'(STEPS));
   assign src_phase = src_big ? PHASE_W'(STEPS - 1)
                              : src[PHASE_W-1:0];
`else
   logic unused_hi;

   assign unused_hi = ^src[7:PHASE_W];
   assign src_big   = 1'b0;
   assign src_phase = src[PHASE_W-1:0];
`endif

   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      skid_full_d = skid_full_q;
      skid_d      = skid_q;
      wr_en_d     = 1'b0;
      wr_addr_d   = wr_addr_q;
      wr_data_d   = wr_data_q;
      ps_d        = boundary;
      apply_d     = 1'b0;
      ferr_d      = 1'b0;
      ovr_d       = 1'b0;
      rerr_d      = 1'b0;
      fcnt_d      = fcnt_q;
      src_vld     = 1'b0;
      src         = skid_q;

      unique case (state_q)
         IDLE: begin
            if (!bus.spi_cs) begin
               state_d = RECV;
               idx_d   = '0;
            end
         end

         RECV: begin
            if (bus.spi_cs) begin
               // Partial frame or an unwritten skid byte: abort.
               ferr_d      = (idx_q != '0) || skid_full_q;
               idx_d       = '0;
               skid_full_d = 1'b0;
               state_d     = IDLE;
            end else begin
               // Held byte goes first; a new arrival takes its place.
               if (skid_full_q) begin
                  src_vld     = 1'b1;
                  src         = skid_q;
                  skid_full_d = bus.rx_valid;
                  if (bus.rx_valid) skid_d = bus.rx_byte;
               end else if (bus.rx_valid) begin
                  src_vld = 1'b1;
                  src     = bus.rx_byte;
               end

               if (src_vld) begin
                  wr_en_d   = 1'b1;
                  wr_addr_d = idx_q;
                  wr_data_d = src_phase;
                  rerr_d    = src_big;
                  if (idx_q == ADDR_W'(NUM_CH - 1)) begin
                     idx_d   = '0;
                     state_d = PENDING;
                  end else begin
                     idx_d = idx_q + 1'b1;
                  end
               end
            end
         end

         PENDING: begin
            if (bus.spi_cs) begin
               ferr_d      = skid_full_q;
               skid_full_d = 1'b0;
            end else if (bus.rx_valid) begin
               if (skid_full_q) begin
                  ovr_d = 1'b1;
               end else begin
                  skid_full_d = 1'b1;
                  skid_d      = bus.rx_byte;
               end
            end

            if (boundary) begin
               apply_d = 1'b1;
               fcnt_d  = fcnt_q + 1'b1;
               state_d = bus.spi_cs ? IDLE : RECV;
            end
         end

         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge master_clock or negedge rst) begin
      if (!rst) begin
         state_q     <= IDLE;
         idx_q       <= '0;
         skid_full_q <= 1'b0;
         skid_q      <= '0;
         per_q       <= '0;
         wr_en_q     <= 1'b0;
         wr_addr_q   <= '0;
         wr_data_q   <= '0;
         ps_q        <= 1'b0;
         apply_q     <= 1'b0;
         ferr_q      <= 1'b0;
         ovr_q       <= 1'b0;
         rerr_q      <= 1'b0;
         fcnt_q      <= '0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         skid_full_q <= skid_full_d;
         skid_q      <= skid_d;
         per_q       <= per_d;
         wr_en_q     <= wr_en_d;
         wr_addr_q   <= wr_addr_d;
         wr_data_q   <= wr_data_d;
         ps_q        <= ps_d;
         apply_q     <= apply_d;
         ferr_q      <= ferr_d;
         ovr_q       <= ovr_d;
         rerr_q      <= rerr_d;
         fcnt_q      <= fcnt_d;
      end
   end

   assign bus.wr_en           = wr_en_q;
   assign bus.wr_addr         = wr_addr_q;
   assign bus.wr_data         = wr_data_q;
   assign bus.period_start    = ps_q;
   assign bus.apply_shift_all = apply_q;
   assign bus.frame_err       = ferr_q;
   assign bus.overrun         = ovr_q;
   assign bus.range_err       = rerr_q;
   assign bus.frame_cnt       = fcnt_q;
endmodule

// File: tb/tb_phase_frame_sequencer.sv
// Randomized bench for phase_frame_sequencer against an event-level
// reference model (write/apply/error cycles from the sequencing rules).
module tb_phase_frame_sequencer;
   localparam int NUM_CH  = 50;
   localparam int PHASE_W = 6;
   localparam int PERIOD  = 1250;

   typedef int iq_t[$];

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   cyc;
   int   total = 0;
   int   bad = 0;

   always #10 clk = ~clk;

   phase_frame_sequencer_if #(.PHASE_W(PHASE_W)) bus ();

   phase_frame_sequencer #(
      .NUM_CH (NUM_CH),
      .PHASE_W(PHASE_W),
      .PERIOD (PERIOD)
   ) dut (
      .master_clock(clk),
      .rst         (rst_n),
      .bus         (bus)
   );

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) cyc <= 0;
      else        cyc <= cyc + 1;
   end

   // expected / recorded event cycles
   iq_t ew_addr, ew_data, ew_cyc, er_cyc, ea_cyc, ee_cyc, eo_cyc;
   iq_t rw_addr, rw_data, rw_cyc, rr_cyc, ra_cyc, re_cyc, ro_cyc;
   int  w_prev, nacc, last_a, napply;

   task automatic chk(input string tag, input int got, input int exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0d exp=%0d @cyc %0d", tag, got, exp, cyc);
      end
   endtask

   function automatic int phase_of(input int b);
`ifdef PHASE_CLAMP_EN
      return (b >= 64) ? 63 : b;
`else
      return b % 64;
`endif
   endfunction

   function automatic bit big_of(input int b);
`ifdef PHASE_CLAMP_EN
      return b >= 64;
`else
      return (b < 0);
`endif
   endfunction

   function automatic int outs();
      return int'({bus.wr_en, bus.wr_addr, bus.wr_data,
                   bus.period_start, bus.apply_shift_all,
                   bus.frame_err, bus.overrun, bus.range_err,
                   bus.frame_cnt});
   endfunction

   always @(negedge clk) begin
      if (rst_n) begin
         automatic bit eps = (cyc > 0) && (cyc % PERIOD == 0);
         if (bus.wr_en) begin
            rw_addr.push_back(int'(bus.wr_addr));
            rw_data.push_back(int'(bus.wr_data));
            rw_cyc.push_back(cyc);
         end
         if (bus.range_err)       rr_cyc.push_back(cyc);
         if (bus.apply_shift_all) ra_cyc.push_back(cyc);
         if (bus.frame_err)       re_cyc.push_back(cyc);
         if (bus.overrun)         ro_cyc.push_back(cyc);
         if (bus.period_start || eps)
            chk("period_start", int'(bus.period_start), int'(eps));
      end
   end

   // A byte on rx_valid during cycle t.
   task automatic model_byte(input int t, input int b);
      int w;
      if (w_prev >= t + 2) begin
         eo_cyc.push_back(t + 1);
         return;
      end
      w = t + 1;
      if (w_prev + 1 > w) w = w_prev + 1;
      if (nacc > 0 && nacc % NUM_CH == 0 && last_a + 1 > w)
         w = last_a + 1;
      ew_addr.push_back(nacc % NUM_CH);
      ew_data.push_back(phase_of(b));
      ew_cyc.push_back(w);
      if (big_of(b)) er_cyc.push_back(w);
      nacc++;
      w_prev = w;
      if (nacc % NUM_CH == 0) begin
         last_a = (w / PERIOD + 1) * PERIOD;
         ea_cyc.push_back(last_a);
      end
   endtask

   // spi_cs high during cycle c: writes not yet done are lost.
   task automatic model_cs_rise(input int c);
      int disc = 0;
      while (ew_cyc.size() > 0 && ew_cyc[$] > c) begin
         if (ew_addr[$] == NUM_CH - 1) void'(ea_cyc.pop_back());
         void'(ew_cyc.pop_back());
         void'(ew_addr.pop_back());
         void'(ew_data.pop_back());
         disc++;
         nacc--;
      end
      while (er_cyc.size() > 0 && er_cyc[$] > c)
         void'(er_cyc.pop_back());
      if (disc > 0 || nacc % NUM_CH != 0) ee_cyc.push_back(c + 1);
   endtask

   task automatic model_clear();
      w_prev = -10;
      nacc   = 0;
      last_a = -10;
      napply = 0;
   endtask

   task automatic cmpq(input string tag, input iq_t got, input iq_t exp);
      chk({tag, "_n"}, got.size(), exp.size());
      for (int i = 0; i < got.size() && i < exp.size(); i++)
         chk(tag, got[i], exp[i]);
   endtask

   task automatic check_txn();
      napply += ea_cyc.size();
      cmpq("wr_addr", rw_addr, ew_addr);
      cmpq("wr_data", rw_data, ew_data);
      cmpq("wr_cyc", rw_cyc, ew_cyc);
      cmpq("range_err", rr_cyc, er_cyc);
      cmpq("apply", ra_cyc, ea_cyc);
      cmpq("frame_err", re_cyc, ee_cyc);
      cmpq("overrun", ro_cyc, eo_cyc);
      chk("frame_cnt", int'(bus.frame_cnt), napply % 256);
      ew_addr.delete(); ew_data.delete(); ew_cyc.delete();
      er_cyc.delete(); ea_cyc.delete(); ee_cyc.delete();
      eo_cyc.delete();
      rw_addr.delete(); rw_data.delete(); rw_cyc.delete();
      rr_cyc.delete(); ra_cyc.delete(); re_cyc.delete();
      ro_cyc.delete();
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic send(input int b);
      bus.rx_valid = 1'b1;
      bus.rx_byte  = 8'(b);
      model_byte(cyc, b);
      @(negedge clk);
      bus.rx_valid = 1'b0;
   endtask

   task automatic cs_low();
      bus.spi_cs = 1'b0;
      nacc   = 0;
      w_prev = -10;
      @(negedge clk);
   endtask

   task automatic wait_until(input int c);
      while (cyc < c) @(negedge clk);
   endtask

   // Raise CS, let pending work drain, then score the transaction.
   task automatic cs_high_settle();
      int c = cyc;
      int tgt;
      bus.spi_cs = 1'b1;
      model_cs_rise(c);
      tgt = c;
      if (last_a > tgt) tgt = last_a;
      if (w_prev > tgt) tgt = w_prev;
      wait_until(tgt + 3);
      check_txn();
   endtask

   task automatic send_n(input int n);
      for (int i = 0; i < n; i++) send(int'($urandom_range(0, 255)));
   endtask

   initial begin
      bus.spi_cs   = 1'b1;
      bus.rx_valid = 1'b0;
      bus.rx_byte  = 8'h00;
      model_clear();
      idle(3);
      chk("reset_outs", outs(), 0);
      rst_n = 1'b1;
      idle(2);
      chk("post_reset_outs", outs(), 0);

      // full frame of 0x3F
      cs_low();
      for (int i = 0; i < NUM_CH; i++) send(8'h3F);
      idle(3);
      cs_high_settle();
      chk("one_frame_cnt", int'(bus.frame_cnt), 1);

      // 23 bytes, first two out of range, then abort
      cs_low();
      send(8'h44);
      send(8'h55);
      send_n(21);
      idle(2);
      cs_high_settle();

      // 100 bytes, byte 51 held in skid across the boundary
      cs_low();
      send_n(NUM_CH);
      send(8'h2A);
      wait_until(last_a + 1);
      send_n(NUM_CH - 1);
      idle(2);
      cs_high_settle();

      // two bytes during PENDING: second one dropped
      cs_low();
      send_n(NUM_CH);
      send(8'h11);
      send(8'h22);
      wait_until(last_a + 2);
      send_n(NUM_CH - 1);
      idle(2);
      cs_high_settle();

      // reset in the middle of a frame
      cs_low();
      send_n(20);
      idle(3);
      check_txn();
      rst_n = 1'b0;
      #1;
      chk("mid_reset_outs", outs(), 0);
      bus.spi_cs = 1'b1;
      @(negedge clk);
      rst_n = 1'b1;
      model_clear();
      idle(2);
      cs_low();
      send_n(5);
      idle(2);
      cs_high_settle();

      // random transactions
      for (int k = 0; k < 6; k++) begin
         int n = int'($urandom_range(1, 110));
         cs_low();
         for (int i = 0; i < n; i++) begin
            int r = int'($urandom_range(0, 99));
            if (r >= 97)      idle(int'($urandom_range(100, 1300)));
            else if (r >= 65) idle(int'($urandom_range(1, 4)));
            send(int'($urandom_range(0, 255)));
         end
         idle(int'($urandom_range(0, 3)));
         cs_high_settle();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/phase_frame_sequencer.md
# phase_frame_sequencer

Sequences phase-shift bytes from the SPI byte receiver into the 50-channel transducer phase bank. Each received byte is assigned to the next channel address, and a complete frame is detected. The shadow-to-active copy (`apply_shift_all`) is issued only on a carrier-period boundary, so no transducer changes phase mid-cycle. The block sits between the SPI receiver and the phase register bank / transducer drivers, in the `master_clock` domain.

## Interface
- `NUM_CH`, 50: transducer channels per frame.
- `PHASE_W`, 6: phase word width (`PHASE_STEPS` = 2^`PHASE_W`).
- `PERIOD`, 1250: `master_clock` cycles per carrier period (50 MHz / 40 kHz).
- `master_clock` in 1: the single clock, 50 MHz, rising edge.
- `rst` in 1: reset, asynchronous, active-low.
- `spi_cs` in 1: SPI chip select, already synchronized to `master_clock`; low = transaction active.
- `rx_valid` in 1: one-cycle pulse, byte received.
- `rx_byte` in 8: received byte, valid with `rx_valid`.
- `wr_en` out 1: shadow-bank write strobe.
- `wr_addr` out 6: channel index, 0..`NUM_CH`-1.
- `wr_data` out `PHASE_W`: phase value.
- `period_start` out 1: one-cycle pulse at carrier-period start.
- `apply_shift_all` out 1: one-cycle pulse that copies shadow to active bank.
- `frame_err` out 1: one-cycle pulse on an aborted partial frame.
- `overrun` out 1: one-cycle pulse when a byte is dropped.
- `range_err` out 1: one-cycle pulse when a byte is clamped (clamp build only; tied 0 otherwise).
- `frame_cnt` out 8: applied-frame counter, wraps 255→0.

## Operation
- All outputs are registered. Reset value of every output is 0; internal index, skid and period counter are also 0; state is IDLE.
- Period counter counts 0..`PERIOD`-1 and wraps. It is free-running and independent of state. `period_start` is 1 in every cycle where the counter is 0.
- **IDLE:** `spi_cs` high; `rx_valid` ignored. `spi_cs` low → RECV with index 0.
- **RECV:** a write source is taken each cycle:
  - Source is the skid register if it is full, else `rx_valid`/`rx_byte`.
  - If both are present, write the skid and load the new byte into the skid.
  - The write issues `wr_en` with `wr_addr` = index, then index increments.
  - Write of index `NUM_CH`-1 → index wraps to 0, state PENDING.
- **PENDING:** waits for `period_start`.
  - That cycle pulses `apply_shift_all`, increments `frame_cnt`, and moves to RECV (IDLE if `spi_cs` high).
  - `rx_valid` in PENDING loads the 1-entry skid.
  - A second `rx_valid` while the skid is full pulses `overrun`; the new byte is dropped and the skid is kept.
- **`spi_cs` rises in RECV:**
  - If index ≠ 0 or the skid is full: pulse `frame_err`, clear index and skid, go to IDLE, no apply.
  - Otherwise go to IDLE quietly.
- **`spi_cs` rises in PENDING:** the completed frame is still applied at the next boundary. If the skid is full, it is discarded with a `frame_err` pulse. Then go to IDLE.
- Consecutive frames within one CS are allowed; the index continues from 0.
- Mid-operation `rst` clears everything asynchronously. An interrupted frame is never applied.

## Timing
- `rx_valid` at cycle N (RECV, skid empty) → `wr_en` at N+1.
- The final write of a frame at cycle N → `apply_shift_all` at the first counter==0 cycle strictly after N (latency 1..`PERIOD` cycles).
- Skid byte is written in the cycle after `apply_shift_all`, at `wr_addr` 0.
- `apply_shift_all` always coincides with `period_start`.
- `frame_err`, `overrun` and `range_err` are single-cycle pulses, aligned with the event cycle +1.

## Configuration
- `PHASE_CLAMP_EN` defined:
  - Bytes ≥ `PHASE_STEPS` saturate to `PHASE_STEPS`-1.
  - `range_err` pulses, aligned with that `wr_en`.
- `PHASE_CLAMP_EN` undefined:
  - `wr_data` = `rx_byte[PHASE_W-1:0]` (modulo).
  - `range_err` is constant 0.

## Test plan
- One CS, 50 × 0x3F → 50 `wr_en` at addr 0..49, data 63; exactly one `apply_shift_all`, on the next `period_start`; `frame_cnt`=1.
- First bytes 0x44, 0x55:
  - With `PHASE_CLAMP_EN`: `wr_data` 63, 63 and two `range_err` pulses.
  - Without it: `wr_data` 4, 21, no `range_err`.
- One CS, 100 bytes, byte 51 arriving in PENDING → held in skid, written at addr 0 the cycle after apply; two applies; `frame_cnt`=2; no `overrun`.
- `spi_cs` high after 23 bytes → one `frame_err`, no apply; next CS starts at `wr_addr` 0.
- Two `rx_valid` pulses during PENDING → one `overrun`; first byte written at addr 0 after apply, second never written.
- `rst` low for 1 cycle after 20 bytes → all outputs 0 immediately; next `rx_valid` (after CS re-entry) writes addr 0; no apply for the aborted frame.
